// File: rtl/adjust_mode_ctrl_pkg.sv
// rtl/adjust_mode_ctrl_pkg.sv - shared types and constants for the adjust-mode controller
package adjust_mode_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ADJUST = 1'b1
  } state_e;

  localparam int BTN_C    = 0;
  localparam int BTN_L    = 1;
  localparam int BTN_R    = 2;
  localparam int BTN_U    = 3;
  localparam int BTN_D    = 4;
  localparam int NUM_BTNS = 5;

  // field0=min, field1=hr, field2=alarm min, field3=alarm hr
  localparam logic [23:0] DEFAULT_MAX_VALUES = {6'd23, 6'd59, 6'd23, 6'd59};

endpackage

// File: rtl/btn_edge_repeat.sv
// rtl/btn_edge_repeat.sv - registered press edge with optional hold-to-auto-repeat
module btn_edge_repeat #(
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic level,
  input  logic en,
  output logic step
);

  // REPEAT_DLY of 0 turns the block into a plain edge detector
  localparam int CW     = $clog2(REPEAT_DLY + 2);
  localparam int RELOAD = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY - REPEAT_RATE : 0;

  logic          prev_q, prev_d;
  logic          step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  always_comb begin
    prev_d = level;
    cnt_d  = cnt_q;
    fire   = 1'b0;
    if (!level || !en || (REPEAT_DLY == 0)) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CW'(REPEAT_DLY - 1)) begin
        fire  = 1'b1;
        cnt_d = CW'(RELOAD);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    step_d = en & ((level & ~prev_q) | fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      step_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/adjust_mode_ctrl.sv
// rtl/adjust_mode_ctrl.sv - button-driven edit of clock/alarm fields with blink and commit
module adjust_mode_ctrl
  import adjust_mode_ctrl_pkg::*;
#(
  parameter int                          NUM_FIELDS  = 4,
  parameter int                          FIELD_W     = 6,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] MAX_VALUES = DEFAULT_MAX_VALUES,
  parameter int                          REPEAT_DLY  = 50,
  parameter int                          REPEAT_RATE = 10,
  parameter int                          BLINK_HALF  = 25
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          c,
  input  logic                          l,
  input  logic                          r,
  input  logic                          u,
  input  logic                          d,
  input  logic [NUM_FIELDS*FIELD_W-1:0] fields_in,
  output logic [NUM_FIELDS*FIELD_W-1:0] fields_out,
  output logic [$clog2(NUM_FIELDS)-1:0] sel,
  output logic                          adj_active,
  output logic [NUM_FIELDS-1:0]         blank_mask,
  output logic                          commit
);

  localparam int SEL_W = $clog2(NUM_FIELDS);
  localparam int BW    = $clog2(BLINK_HALF + 1);

  state_e                        state_q, state_d;
  logic [NUM_FIELDS*FIELD_W-1:0] fields_q, fields_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic                          phase_q, phase_d;
  logic [BW-1:0]                 bcnt_q, bcnt_d;
  logic                          commit_q, commit_d;

  logic [NUM_BTNS-1:0] lvl, step;
  logic [FIELD_W-1:0]  cur, cur_max;
  logic                blink_rst;

  always_comb begin
    lvl        = '0;
    lvl[BTN_C] = c;
    lvl[BTN_L] = l;
    lvl[BTN_R] = r;
    lvl[BTN_U] = u;
    lvl[BTN_D] = d;
  end

  btn_edge_repeat #(.REPEAT_DLY(0), .REPEAT_RATE(1)) u_btn_c (
    .clk(clk), .rst(rst), .tick(tick), .level(lvl[BTN_C]), .en(1'b1), .step(step[BTN_C]));
  btn_edge_repeat #(.REPEAT_DLY(0), .REPEAT_RATE(1)) u_btn_l (
    .clk(clk), .rst(rst), .tick(tick), .level(lvl[BTN_L]), .en(1'b1), .step(step[BTN_L]));
  btn_edge_repeat #(.REPEAT_DLY(0), .REPEAT_RATE(1)) u_btn_r (
    .clk(clk), .rst(rst), .tick(tick), .level(lvl[BTN_R]), .en(1'b1), .step(step[BTN_R]));
  // holding the opposite direction suppresses steps and clears the hold count
  btn_edge_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_btn_u (
    .clk(clk), .rst(rst), .tick(tick), .level(lvl[BTN_U]), .en(~lvl[BTN_D]), .step(step[BTN_U]));
  btn_edge_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_btn_d (
    .clk(clk), .rst(rst), .tick(tick), .level(lvl[BTN_D]), .en(~lvl[BTN_U]), .step(step[BTN_D]));

  always_comb begin
    state_d   = state_q;
    fields_d  = fields_q;
    sel_d     = sel_q;
    phase_d   = phase_q;
    bcnt_d    = bcnt_q;
    commit_d  = 1'b0;
    blink_rst = 1'b0;
    cur       = fields_q[sel_q*FIELD_W +: FIELD_W];
    cur_max   = MAX_VALUES[sel_q*FIELD_W +: FIELD_W];

    case (state_q)
      ST_IDLE: begin
        fields_d = fields_in;
        if (step[BTN_C]) begin
          state_d   = ST_ADJUST;
          sel_d     = '0;
          blink_rst = 1'b1;
        end
      end
      ST_ADJUST: begin
        if (step[BTN_C]) begin
          state_d  = ST_IDLE;
          commit_d = 1'b1;
        end else if (step[BTN_L] || step[BTN_R]) begin
          if (step[BTN_R] && !step[BTN_L]) begin
            sel_d     = (sel_q == SEL_W'(NUM_FIELDS - 1)) ? '0 : sel_q + 1'b1;
            blink_rst = 1'b1;
          end else if (step[BTN_L] && !step[BTN_R]) begin
            sel_d     = (sel_q == '0) ? SEL_W'(NUM_FIELDS - 1) : sel_q - 1'b1;
            blink_rst = 1'b1;
          end
        end else if (step[BTN_U] && !step[BTN_D]) begin
          fields_d[sel_q*FIELD_W +: FIELD_W] = (cur == cur_max) ? '0 : cur + 1'b1;
          blink_rst = 1'b1;
        end else if (step[BTN_D] && !step[BTN_U]) begin
          fields_d[sel_q*FIELD_W +: FIELD_W] = (cur == '0) ? cur_max : cur - 1'b1;
          blink_rst = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (blink_rst || state_q != ST_ADJUST) begin
      phase_d = 1'b0;
      bcnt_d  = '0;
    end else if (tick) begin
      if (bcnt_q == BW'(BLINK_HALF - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      fields_q <= '0;
      sel_q    <= '0;
      phase_q  <= 1'b0;
      bcnt_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      sel_q    <= sel_d;
      phase_q  <= phase_d;
      bcnt_q   <= bcnt_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    blank_mask = '0;
    if (state_q == ST_ADJUST && phase_q) blank_mask[sel_q] = 1'b1;
  end

  assign fields_out = fields_q;
  assign sel        = sel_q;
  assign adj_active = (state_q == ST_ADJUST);
  assign commit     = commit_q;

endmodule

// File: tb/tb_adjust_mode_ctrl.sv
// tb/tb_adjust_mode_ctrl.sv - directed vector bench for adjust_mode_ctrl
module tb_adjust_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick, c, l, r, u, d;
  logic [23:0] fields_in, fields_out;
  logic [1:0]  sel;
  logic        adj_active, commit;
  logic [3:0]  blank_mask;

  adjust_mode_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .c(c), .l(l), .r(r), .u(u), .d(d),
    .fields_in(fields_in), .fields_out(fields_out), .sel(sel),
    .adj_active(adj_active), .blank_mask(blank_mask), .commit(commit));

  always #5 clk = ~clk;

  typedef struct {
    logic       bc, bl, br, bu, bd;
    logic [1:0] exp_sel;
    logic [5:0] exp_f0, exp_f1;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   commits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(2);
    end
  endtask

  function automatic logic [23:0] pack(input logic [5:0] f3, f2, f1, f0);
    return {f3, f2, f1, f0};
  endfunction

  function automatic vec_t mk(input logic bc, bl, br, bu, bd,
                              input logic [1:0] s, input logic [5:0] f0, f1);
    vec_t v;
    v.bc = bc; v.bl = bl; v.br = br; v.bu = bu; v.bd = bd;
    v.exp_sel = s; v.exp_f0 = f0; v.exp_f1 = f1;
    return v;
  endfunction

  initial begin
    rst = 1'b1; tick = 1'b0; c = 1'b0; l = 1'b0; r = 1'b0; u = 1'b0; d = 1'b0;
    fields_in = pack(6'd23, 6'd59, 6'd23, 6'd59);

    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd59, 6'd23);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 6'd59, 6'd23);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6'd59, 6'd23);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 6'd59, 6'd23);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd59, 6'd23);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  6'd23);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd59, 6'd23);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 6'd59, 6'd23);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 6'd59, 6'd0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 6'd59, 6'd23);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 6'd59, 6'd23);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6'd59, 6'd23);

    @(negedge clk);
    cyc(2);
    chk("rst_fields", 32'(fields_out), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_adj", 32'(adj_active), 0);
    chk("rst_blank", 32'(blank_mask), 0);
    chk("rst_commit", 32'(commit), 0);

    rst = 1'b0;
    cyc(1);
    chk("idle_track0", 32'(fields_out), 32'(pack(6'd23, 6'd59, 6'd23, 6'd59)));
    fields_in = pack(6'd5, 6'd6, 6'd7, 6'd8);
    cyc(1);
    chk("idle_track1", 32'(fields_out), 32'(pack(6'd5, 6'd6, 6'd7, 6'd8)));
    chk("idle_adj", 32'(adj_active), 0);
    fields_in = pack(6'd23, 6'd59, 6'd23, 6'd59);
    cyc(1);

    for (int i = 0; i < 12; i++) begin
      c = vecs[i].bc; l = vecs[i].bl; r = vecs[i].br; u = vecs[i].bu; d = vecs[i].bd;
      cyc(1);
      c = 1'b0; l = 1'b0; r = 1'b0; u = 1'b0; d = 1'b0;
      cyc(3);
      chk($sformatf("vec%0d_adj", i), 32'(adj_active), 1);
      chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_f0", i), 32'(fields_out[5:0]), 32'(vecs[i].exp_f0));
      chk($sformatf("vec%0d_f1", i), 32'(fields_out[11:6]), 32'(vecs[i].exp_f1));
      chk($sformatf("vec%0d_blank", i), 32'(blank_mask), 0);
    end

    fields_in = pack(6'd1, 6'd2, 6'd3, 6'd4);
    cyc(1);
    chk("frozen", 32'(fields_out), 32'(pack(6'd23, 6'd59, 6'd23, 6'd59)));

    u = 1'b1;
    cyc(1);
    chk("lat_edge1", 32'(fields_out[5:0]), 59);
    cyc(1);
    chk("lat_edge2", 32'(fields_out[5:0]), 0);
    u = 1'b0;
    cyc(2);
    d = 1'b1;
    cyc(1);
    d = 1'b0;
    cyc(3);
    chk("down_wrap", 32'(fields_out[5:0]), 59);

    commits = 0;
    c = 1'b1; u = 1'b1;
    cyc(1);
    c = 1'b0; u = 1'b0;
    commits += int'(commit);
    chk("exit_adj_still", 32'(adj_active), 1);
    cyc(1);
    commits += int'(commit);
    chk("exit_commit", 32'(commit), 1);
    chk("exit_adj", 32'(adj_active), 0);
    chk("exit_hold", 32'(fields_out), 32'(pack(6'd23, 6'd59, 6'd23, 6'd59)));
    cyc(1);
    commits += int'(commit);
    chk("exit_resume", 32'(fields_out), 32'(pack(6'd1, 6'd2, 6'd3, 6'd4)));
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      commits += int'(commit);
    end
    chk("commit_once", 32'(commits), 1);

    fields_in = pack(6'd1, 6'd2, 6'd3, 6'd10);
    cyc(1);
    c = 1'b1;
    cyc(1);
    c = 1'b0;
    cyc(3);
    chk("reenter_adj", 32'(adj_active), 1);
    chk("reenter_sel", 32'(sel), 0);
    u = 1'b1;
    do_tick(50);
    chk("hold50", 32'(fields_out[5:0]), 12);
    do_tick(50);
    u = 1'b0;
    cyc(4);
    chk("hold100", 32'(fields_out[5:0]), 17);
    do_tick(20);
    chk("released", 32'(fields_out[5:0]), 17);

    u = 1'b1; d = 1'b1;
    cyc(2);
    do_tick(60);
    u = 1'b0; d = 1'b0;
    cyc(3);
    chk("ud_together", 32'(fields_out[5:0]), 17);

    r = 1'b1;
    cyc(1);
    r = 1'b0;
    cyc(3);
    chk("blink_sel", 32'(sel), 1);
    chk("blink_start", 32'(blank_mask), 0);
    do_tick(24);
    chk("blink_24", 32'(blank_mask), 0);
    do_tick(1);
    chk("blink_25", 32'(blank_mask), 32'(4'b0010));
    do_tick(24);
    chk("blink_49", 32'(blank_mask), 32'(4'b0010));
    do_tick(1);
    chk("blink_50", 32'(blank_mask), 0);
    do_tick(25);
    chk("blink_75", 32'(blank_mask), 32'(4'b0010));

    rst = 1'b1;
    cyc(1);
    chk("midrst_adj", 32'(adj_active), 0);
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_blank", 32'(blank_mask), 0);
    chk("midrst_fields", 32'(fields_out), 0);
    rst = 1'b0;
    commits = int'(commit);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      commits += int'(commit);
    end
    chk("midrst_nocommit", 32'(commits), 0);
    chk("midrst_track", 32'(fields_out), 32'(pack(6'd1, 6'd2, 6'd3, 6'd10)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
